// File: rtl/sumador_serie_param.sv
// sumador_serie_param: digit-serial adder/subtractor, DIGIT bits per clock over WIDTH-bit operands
//   clk, rst (sync, active-high), start (taken when busy=0), sub (0 add, 1 subtract),
//   a, b, ci (carry-in / borrow-in) are the inputs;
//   busy, done (one-cycle pulse), s, co (raw MSB carry) and ovf (signed overflow) are the outputs.
//   The s, co and ovf outputs hold their value until the next done.
module sumador_serie_param_fa #(
    parameter int PwrC = 0
) (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);
    // PwrC is only carried for power annotation of the cell; it does not change the logic
    if (PwrC < 0) begin : g_pwr_neg
    end
    assign s  = x ^ y ^ c;
    assign co = (x & y) | (c & (x ^ y));
endmodule

module sumador_serie_param #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter int PwrC  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ra, rb, acc, acc_n;
    logic             carry;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] sd;
    logic             accept, last;
    assign accept = start && state != BUSY;
    assign last   = state == BUSY && cnt == CW'(NDIG - 1);
    assign c[0]   = carry;
    // new digit enters at the top so the first digit ends at the LSB after NDIG shifts
    assign acc_n  = WIDTH'({sd, acc} >> DIGIT);
    for (genvar g = 0; g < DIGIT; g++) begin : g_cell
        sumador_serie_param_fa #(.PwrC(PwrC)) u_fa (
            .x(ra[g]), .y(rb[g]), .c(c[g]), .s(sd[g]), .co(c[g+1])
        );
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = accept ? BUSY : last ? DONE : state == DONE ? IDLE : state;
        busy    = state == BUSY;
        done    = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            ra    <= a;
            rb    <= b ^ {WIDTH{sub}};
            carry <= ci ^ sub;
            cnt   <= '0;
        end else if (state == BUSY) begin
            ra    <= ra >> DIGIT;
            rb    <= rb >> DIGIT;
            carry <= c[DIGIT];
            acc   <= acc_n;
            cnt   <= cnt + 1'b1;
            if (last) begin
                s   <= acc_n;
                co  <= c[DIGIT];
                ovf <= c[DIGIT] ^ c[DIGIT-1];
            end
        end
    end
endmodule

// File: tb/tb_sumador_serie_param.sv
// tb_sumador_serie_param: checks the digit-serial adder against a cycle-level arithmetic model
module tb_sumador_serie_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, sub, ci, busy, done, co, ovf;
    logic [15:0] a, b, s;
    logic start8, sub8, ci8, busy8, done8, co8, ovf8, busy1, done1, co1, ovf1;
    logic [7:0] a8, b8, s8, s1;

    int errs = 0, checks = 0;
    logic cmp_en = 1'b0;

    sumador_serie_param #(.WIDTH(16), .DIGIT(4), .PwrC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
    );
    sumador_serie_param #(.WIDTH(8), .DIGIT(8), .PwrC(0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8)
    );
    sumador_serie_param #(.WIDTH(8), .DIGIT(1), .PwrC(0)) dut1 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference result {ovf, co, s} from plain arithmetic and the sign rule
    function automatic logic [17:0] ref16(logic [15:0] x, logic [15:0] y, logic c, logic sb);
        logic [15:0] yy;
        logic [16:0] r;
        logic v;
        yy = sb ? ~y : y;
        r = {1'b0, x} + {1'b0, yy} + {16'd0, c ^ sb};
        v = (x[15] == yy[15]) && (r[15] != x[15]);
        return {v, r};
    endfunction

    // model: accepted start schedules the result 4 cycles later
    logic m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_s = '0;
    logic [17:0] m_pend = '0;
    int m_left = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_s <= '0;
            m_co <= 1'b0;
            m_ovf <= 1'b0;
        end else if (start && !m_busy) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_left <= 4;
            m_pend <= ref16(a, b, ci, sub);
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_ovf, m_co, m_s} <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_s", s, m_s);
            chk("cyc_co", co, m_co);
            chk("cyc_ovf", ovf, m_ovf);
        end
    end

    task automatic run16(string nm, logic [15:0] x, logic [15:0] y, logic c, logic sb,
                         logic [15:0] es, logic eco, logic eov);
        int n = 0;
        a = x; b = y; ci = c; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, n, 4);
        chk({nm, "_s"}, s, es);
        chk({nm, "_co"}, co, eco);
        chk({nm, "_ovf"}, ovf, eov);
        @(negedge clk);
    endtask

    initial begin
        int d1, d2;
        int n;
        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sub8 = 1'b0; ci8 = 1'b0; a8 = '0; b8 = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_co", co, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_done1", done1, 0);
        rst = 1'b0;
        @(negedge clk);

        run16("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run16("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run16("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run16("novf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // abort mid-operation: reset sampled at E2
        a = 16'h1111; b = 16'h2222; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_s", s, 0);
        d1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) d1++;
        end
        chk("abort_nodone", d1, 0);

        // start held through busy and into DONE: first result untouched, second accepted at E5
        a = 16'h1234; b = 16'h4321; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001;
        d1 = -1; d2 = -1;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 5) start = 1'b0;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    chk("b2b_s1", s, 16'h5555);
                end else begin
                    d2 = n;
                    chk("b2b_s2", s, 16'h0000);
                    chk("b2b_co2", co, 1);
                end
            end
        end
        chk("b2b_lat1", d1, 4);
        chk("b2b_lat2", d2, 9);

        // 8-bit instances: single digit and bit-serial
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        d1 = -1; d2 = -1;
        for (n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done8 && d1 < 0) begin
                d1 = n;
                chk("w8d8_s", s8, 8'h01);
                chk("w8d8_co", co8, 1);
                chk("w8d8_ovf", ovf8, 1);
            end
            if (done1 && d2 < 0) begin
                d2 = n;
                chk("w8d1_s", s1, 8'h01);
                chk("w8d1_co", co1, 1);
                chk("w8d1_ovf", ovf1, 1);
            end
        end
        chk("w8d8_lat", d1, 1);
        chk("w8d1_lat", d2, 8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
